// File: rtl/ksa_share_arbiter.sv
// ksa_share_arbiter: round-robin front end that time-shares one external
// 64-bit Kogge-Stone adder between NREQ requesters. An operand register
// feeds the adder and a result register holds the tagged sum until the
// consumer takes it. Results leave in acceptance order.
module ksa_share_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [64*NREQ-1:0]   req_a,
   input  logic [64*NREQ-1:0]   req_b,
   input  logic [NREQ-1:0]      req_cin,
   output logic [63:0]          ksa_a,
   output logic [63:0]          ksa_b,
   output logic                 ksa_cin,
   input  logic [63:0]          ksa_sum,
   input  logic                 ksa_cout,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [63:0]          rsp_sum,
   output logic                 rsp_cout,
   output logic                 busy
);

   // Round-robin pointer and operand stage
   logic [IDW-1:0]      ptr_r;
   logic                op_valid_r;
   logic [IDW-1:0]      op_id_r;
   logic [63:0]         ksa_a_r;
   logic [63:0]         ksa_b_r;
   logic                ksa_cin_r;

   // Result stage
   logic                rsp_valid_r;
   logic [IDW-1:0]      rsp_id_r;
   logic [63:0]         rsp_sum_r;
   logic                rsp_cout_r;

   // Handshake and arbitration terms
   logic                advance_s;
   logic                op_free_s;
   logic [2*NREQ-1:0]   dbl_valid_s;
   logic [NREQ-1:0]     rot_valid_s;
   logic [IDW-1:0]      off_s;
   logic                hit_s;
   logic [IDW:0]        grant_sum_s;
   logic [IDW-1:0]      grant_s;
   logic [IDW-1:0]      next_ptr_s;
   logic                accept_s;
   logic [63:0]         sel_a_s;
   logic [63:0]         sel_b_s;
   logic                sel_cin_s;

   // The result stage can take new data when empty or being drained;
   // the op stage can take new data when empty or moving forward.
   assign advance_s = ~rsp_valid_r | rsp_ready;
   assign op_free_s = ~op_valid_r | advance_s;

   // Rotate the valid vector so the pointer's requester lands on bit 0,
   // then find the lowest set bit (scanning high to low, lowest wins).
   always_comb begin
      dbl_valid_s = {req_valid, req_valid};
      rot_valid_s = NREQ'(dbl_valid_s >> ptr_r);
      off_s       = '0;
      hit_s       = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         off_s = rot_valid_s[k] ? IDW'(k) : off_s;
         hit_s = hit_s | rot_valid_s[k];
      end
   end

   // Map the rotated offset back to an absolute index and derive the
   // pointer value that follows an acceptance of that index.
   always_comb begin
      grant_sum_s = {1'b0, ptr_r} + {1'b0, off_s};
      if (grant_sum_s >= (IDW+1)'(NREQ)) begin
         grant_s = IDW'(grant_sum_s - (IDW+1)'(NREQ));
      end else begin
         grant_s = grant_sum_s[IDW-1:0];
      end
      if (grant_s == IDW'(NREQ - 1)) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = grant_s + IDW'(1);
      end
   end

   // Grant handshake and operand select; ready is held low during reset.
   always_comb begin
      accept_s = hit_s & op_free_s & ~rst;
      if (accept_s) begin
         req_ready = {{(NREQ-1){1'b0}}, 1'b1} << grant_s;
      end else begin
         req_ready = '0;
      end
      sel_a_s   = 64'(req_a >> {grant_s, 6'b000000});
      sel_b_s   = 64'(req_b >> {grant_s, 6'b000000});
      sel_cin_s = req_cin[grant_s];
   end

   // Operand stage: load on acceptance, otherwise empty it once it moves on.
   // The adder operand registers keep their last value when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_r      <= '0;
         op_valid_r <= 1'b0;
         op_id_r    <= '0;
         ksa_a_r    <= 64'd0;
         ksa_b_r    <= 64'd0;
         ksa_cin_r  <= 1'b0;
      end else begin
         if (accept_s) begin
            ksa_a_r    <= sel_a_s;
            ksa_b_r    <= sel_b_s;
            ksa_cin_r  <= sel_cin_s;
            op_id_r    <= grant_s;
            op_valid_r <= 1'b1;
            ptr_r      <= next_ptr_s;
         end else if (op_valid_r & advance_s) begin
            op_valid_r <= 1'b0;
         end else begin
            op_valid_r <= op_valid_r;
         end
      end
   end

   // Result stage: capture the adder output as the op moves forward,
   // otherwise clear on consumer handshake; data stays frozen on stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= '0;
         rsp_sum_r   <= 64'd0;
         rsp_cout_r  <= 1'b0;
      end else begin
         if (op_valid_r & advance_s) begin
            rsp_sum_r   <= ksa_sum;
            rsp_cout_r  <= ksa_cout;
            rsp_id_r    <= op_id_r;
            rsp_valid_r <= 1'b1;
         end else if (rsp_valid_r & rsp_ready) begin
            rsp_valid_r <= 1'b0;
         end else begin
            rsp_valid_r <= rsp_valid_r;
         end
      end
   end

   assign ksa_a     = ksa_a_r;
   assign ksa_b     = ksa_b_r;
   assign ksa_cin   = ksa_cin_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_id    = rsp_id_r;
   assign rsp_sum   = rsp_sum_r;
   assign rsp_cout  = rsp_cout_r;
   assign busy      = op_valid_r | rsp_valid_r;

endmodule
